// File: rtl/wb_port_writer.sv
// Write-back port driver: merges 1-cycle ALU results with FIFO-buffered load results onto
// the register-file write port and tracks pending writes per register. Optional: WB_PERF_CNT_EN.
module wb_port_writer #(
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [DW-1:0]            alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_rd,
  input  logic [DW-1:0]            ld_data,
  input  logic                     iss_valid,
  input  logic [4:0]               iss_rd,
  input  logic [4:0]               q_ra1,
  input  logic [4:0]               q_ra2,
  output logic                     q_busy1,
  output logic                     q_busy2,
  output logic                     we3,
  output logic [4:0]               wa3,
  output logic [DW-1:0]            wd3,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              defer_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [4:0]  XZR = 5'd31;

  logic [4:0]    mem_rd   [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [31:0]   pending, pending_nxt;

  logic          full, empty, push, pop, alu_eff, wr_en;
  logic [4:0]    wr_addr;
  logic [DW-1:0] wr_data;

  // Load handshake: a load transfers on a cycle where ld_valid && ld_ready; ld_ready
  // depends only on the registered level, so a same-cycle pop never frees a slot early.
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign fifo_level = wr_ptr - rd_ptr;
  assign ld_ready   = !full;

  assign alu_eff = alu_valid && (alu_rd != XZR);
  assign push    = ld_valid && ld_ready && (ld_rd != XZR);
  assign pop     = !alu_eff && !empty;
  assign wr_en   = alu_eff || pop;
  assign wr_addr = alu_eff ? alu_rd   : mem_rd[rd_ptr[AW-1:0]];
  assign wr_data = alu_eff ? alu_data : mem_data[rd_ptr[AW-1:0]];

  assign q_busy1 = pending[q_ra1];
  assign q_busy2 = pending[q_ra2];

  // An issue to the register being written on this edge re-arms it (set beats clear).
  always_comb begin
    pending_nxt = pending;
    if (wr_en) pending_nxt[wr_addr] = 1'b0;
    if (iss_valid && (iss_rd != XZR)) pending_nxt[iss_rd] = 1'b1;
    pending_nxt[31] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr[AW-1:0]]   <= ld_rd;
      mem_data[wr_ptr[AW-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
      we3     <= 1'b0;
      wa3     <= XZR;
      wd3     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      pending <= pending_nxt;
      we3     <= wr_en;
      if (wr_en) begin
        wa3 <= wr_addr;
        wd3 <= wr_data;
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      defer_cnt <= '0;
    end else begin
      if (ld_valid && !ld_ready && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (alu_eff && !empty && (defer_cnt != 32'hFFFF_FFFF))     defer_cnt <= defer_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_writer.sv
// Bench for wb_port_writer: directed vector table, hand sequences for fill/reset corners,
// and random traffic, all checked against a queue-based reference model.
module tb_wb_port_writer;
  localparam int DEPTH = 4;
  localparam int DW    = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          alu_valid = 1'b0;
  logic [4:0]    alu_rd = '0;
  logic [DW-1:0] alu_data = '0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [4:0]    ld_rd = '0;
  logic [DW-1:0] ld_data = '0;
  logic          iss_valid = 1'b0;
  logic [4:0]    iss_rd = '0;
  logic [4:0]    q_ra1 = '0;
  logic [4:0]    q_ra2 = '0;
  logic          q_busy1, q_busy2, we3;
  logic [4:0]    wa3;
  logic [DW-1:0] wd3;
  logic [2:0]    fifo_level;
`ifdef WB_PERF_CNT_EN
  logic [31:0]   stall_cnt, defer_cnt;
`endif

  wb_port_writer #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .q_ra1(q_ra1), .q_ra2(q_ra2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .we3(we3), .wa3(wa3), .wd3(wd3), .fifo_level(fifo_level)
`ifdef WB_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .defer_cnt(defer_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  logic [68:0]   exp_q[$];     // {rd, data} in acceptance order
  bit   [31:0]   pend;
  logic          m_we;
  logic [4:0]    m_wa;
  logic [DW-1:0] m_wd;
  int unsigned   m_stall, m_defer;
  int            checks = 0;
  int            errors = 0;
  logic          last_acc;

  typedef struct {
    logic          alu_v; logic [4:0] alu_r; logic [DW-1:0] alu_d;
    logic          ld_v;  logic [4:0] ld_r;  logic [DW-1:0] ld_d;
    logic          iss_v; logic [4:0] iss_r; logic [4:0] qa;
    logic          e_we;  logic [4:0] e_wa;  logic [DW-1:0] e_wd;
    logic [2:0]    e_lvl; logic e_busy;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend = '0;
    m_we = 1'b0; m_wa = 5'd31; m_wd = '0;
    m_stall = 0; m_defer = 0;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; ld_valid = 1'b0; iss_valid = 1'b0;
  endtask

  // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
  task automatic cycle();
    logic        rdy, alu_eff;
    logic [68:0] h;
    #3;
    rdy = (exp_q.size() < DEPTH);
    chk("ld_ready", ld_ready, rdy);
    chk("fifo_level", fifo_level, exp_q.size());
    chk("q_busy1", q_busy1, pend[q_ra1]);
    chk("q_busy2", q_busy2, pend[q_ra2]);
    last_acc = ld_valid && rdy;
    alu_eff  = alu_valid && (alu_rd != 5'd31);
    if (ld_valid && !rdy) m_stall++;
    if (alu_eff && exp_q.size() > 0) m_defer++;
    if (alu_eff) begin
      m_we = 1'b1; m_wa = alu_rd; m_wd = alu_data;
    end else if (exp_q.size() > 0) begin
      h = exp_q.pop_front();
      m_we = 1'b1; m_wa = h[68:64]; m_wd = h[63:0];
    end else begin
      m_we = 1'b0;
    end
    if (ld_valid && rdy && ld_rd != 5'd31) exp_q.push_back({ld_rd, ld_data});
    if (m_we) pend[m_wa] = 1'b0;
    if (iss_valid && iss_rd != 5'd31) pend[iss_rd] = 1'b1;
    @(posedge clk);
    #1;
    chk("we3", we3, m_we);
    chk("wa3", wa3, m_wa);
    chk("wd3", wd3, m_wd);
  endtask

  function automatic logic [4:0] rand_rd();
    return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    int k;
    //            alu_v rd   data   ld_v rd   data  iss_v rd  qa   we wa  wd     lvl busy
    tbl[0]  = '{1'b0, 5'd0, 64'h0,   1'b0, 5'd0, 64'h0,  1'b1, 5'd5,  5'd5,  1'b0, 5'd31, 64'h0,   3'd0, 1'b1};
    tbl[1]  = '{1'b1, 5'd5, 64'hAA,  1'b0, 5'd0, 64'h0,  1'b0, 5'd0,  5'd5,  1'b1, 5'd5,  64'hAA,  3'd0, 1'b0};
    tbl[2]  = '{1'b1, 5'd3, 64'h33,  1'b1, 5'd7, 64'h77, 1'b0, 5'd0,  5'd7,  1'b1, 5'd3,  64'h33,  3'd1, 1'b0};
    tbl[3]  = '{1'b0, 5'd0, 64'h0,   1'b0, 5'd0, 64'h0,  1'b0, 5'd0,  5'd7,  1'b1, 5'd7,  64'h77,  3'd0, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 64'h0,   1'b0, 5'd0, 64'h0,  1'b0, 5'd0,  5'd7,  1'b0, 5'd7,  64'h77,  3'd0, 1'b0};
    tbl[5]  = '{1'b1, 5'd31, 64'h1,  1'b1, 5'd31, 64'h2, 1'b1, 5'd31, 5'd31, 1'b0, 5'd7,  64'h77,  3'd0, 1'b0};
    tbl[6]  = '{1'b0, 5'd0, 64'h0,   1'b0, 5'd0, 64'h0,  1'b1, 5'd9,  5'd9,  1'b0, 5'd7,  64'h77,  3'd0, 1'b1};
    tbl[7]  = '{1'b1, 5'd9, 64'h99,  1'b0, 5'd0, 64'h0,  1'b1, 5'd9,  5'd9,  1'b1, 5'd9,  64'h99,  3'd0, 1'b1};
    tbl[8]  = '{1'b1, 5'd9, 64'h100, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0,  5'd9,  1'b1, 5'd9,  64'h100, 3'd0, 1'b0};
    tbl[9]  = '{1'b1, 5'd1, 64'h11,  1'b1, 5'd12, 64'hC, 1'b0, 5'd0,  5'd1,  1'b1, 5'd1,  64'h11,  3'd1, 1'b0};
    tbl[10] = '{1'b0, 5'd0, 64'h0,   1'b1, 5'd13, 64'hD, 1'b0, 5'd0,  5'd12, 1'b1, 5'd12, 64'hC,   3'd1, 1'b0};
    tbl[11] = '{1'b0, 5'd0, 64'h0,   1'b0, 5'd0, 64'h0,  1'b0, 5'd0,  5'd13, 1'b1, 5'd13, 64'hD,   3'd0, 1'b0};

    // reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we3", we3, 1'b0);
    chk("rst_wa3", wa3, 5'd31);
    chk("rst_wd3", wd3, 64'h0);
    chk("rst_level", fifo_level, 3'd0);
    chk("rst_ready", ld_ready, 1'b1);
    reset = 1'b1;

    // directed vector table
    for (int i = 0; i < 12; i++) begin
      alu_valid = tbl[i].alu_v; alu_rd = tbl[i].alu_r; alu_data = tbl[i].alu_d;
      ld_valid  = tbl[i].ld_v;  ld_rd  = tbl[i].ld_r;  ld_data  = tbl[i].ld_d;
      iss_valid = tbl[i].iss_v; iss_rd = tbl[i].iss_r;
      q_ra1 = tbl[i].qa; q_ra2 = 5'($urandom_range(0, 31));
      cycle();
      chk($sformatf("tbl%0d_we3", i), we3, tbl[i].e_we);
      chk($sformatf("tbl%0d_wa3", i), wa3, tbl[i].e_wa);
      chk($sformatf("tbl%0d_wd3", i), wd3, tbl[i].e_wd);
      chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].e_lvl);
      chk($sformatf("tbl%0d_busy", i), q_busy1, tbl[i].e_busy);
    end
    idle_inputs();

    // FIFO fill under continuous ALU traffic, then drain in acceptance order
    k = 0;
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 64'h5000 + 64'(i);
      ld_valid = 1'b1; ld_rd = 5'(10 + k); ld_data = 64'h100 + 64'(k);
      cycle();
      if (last_acc) k++;
    end
    chk("fill_accepted", k, 4);
    chk("fill_level", fifo_level, 3'd4);
    chk("fill_ready", ld_ready, 1'b0);
    alu_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ld_valid = (k < 5); ld_rd = 5'(10 + k); ld_data = 64'h100 + 64'(k);
      cycle();
      if (last_acc) k++;
    end
    chk("fill_all_accepted", k, 5);
    chk("fill_last_wa3", wa3, 5'd14);
    chk("fill_drained", fifo_level, 3'd0);
    idle_inputs();

    // asynchronous reset while loads are queued and registers pending
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 64'hBEEF;
      ld_valid = 1'b1; ld_rd = 5'(15 + i); ld_data = 64'h700 + 64'(i);
      iss_valid = 1'b1; iss_rd = 5'(20 + i); q_ra1 = 5'd20; q_ra2 = 5'd22;
      cycle();
    end
    idle_inputs();
    chk("pre_rst_level", fifo_level, 3'd3);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_we3", we3, 1'b0);
    chk("mid_rst_level", fifo_level, 3'd0);
    chk("mid_rst_busy1", q_busy1, 1'b0);
    chk("mid_rst_busy2", q_busy2, 1'b0);
    chk("mid_rst_ready", ld_ready, 1'b1);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      alu_valid = ($urandom_range(0, 99) < 40);
      alu_rd    = rand_rd();
      alu_data  = {$urandom, $urandom};
      ld_valid  = ($urandom_range(0, 99) < 55);
      ld_rd     = rand_rd();
      ld_data   = {$urandom, $urandom};
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd    = rand_rd();
      q_ra1     = rand_rd();
      q_ra2     = 5'($urandom_range(0, 31));
      cycle();
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) cycle();
    chk("final_level", fifo_level, 3'd0);

`ifdef WB_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("defer_cnt", defer_cnt, m_defer);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
